// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module  : iterative_divider
// Brief   : Radix-2 restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient and
//           remainder, one quotient bit per clock, valid/ready on both sides.
// Revision: 1.0
// ============================================================================
module iterative_divider #(
  parameter int WIDTH = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int               CNT_W  = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_q_next;

  assign w_hi = dividend[2*WIDTH-1:WIDTH];
  assign w_lo = dividend[WIDTH-1:0];

  // The partial remainder stays below the divisor, so after either branch it
  // fits in WIDTH bits; only the shifted trial value needs the extra bit.
  always_comb begin
    w_trial    = {r_rem, r_q[WIDTH-1]};
    w_qbit     = (w_trial >= {1'b0, r_div});
    w_rem_next = w_qbit ? WIDTH'(w_trial - {1'b0, r_div}) : w_trial[WIDTH-1:0];
    w_q_next   = {r_q[WIDTH-2:0], w_qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      r_rem       <= '0;
      r_q         <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_div    <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              r_state     <= S_DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
              quotient    <= '1;
              remainder   <= w_lo;
            end else if (w_hi >= divisor) begin
              // Quotient would need more than WIDTH bits.
              r_state     <= S_DONE;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
              quotient    <= '1;
              remainder   <= '0;
            end else begin
              r_state <= S_CALC;
              r_rem   <= w_hi;
              r_q     <= w_lo;
              r_cnt   <= '0;
            end
          end
        end

        S_CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == C_LAST) begin
            r_state     <= S_DONE;
            out_valid   <= 1'b1;
            quotient    <= w_q_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_iterative_divider
// Brief   : Directed and random checks of iterative_divider at WIDTH=8 and 27.
// Revision: 1.0
// ============================================================================
module tb_iterative_divider;

  localparam int W8   = 8;
  localparam int W27  = 27;
  localparam int N27  = 1500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic              rst8_n;
  logic              in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2*W8-1:0]   dividend8;
  logic [W8-1:0]     divisor8, quotient8, remainder8;
  logic              dz8, ov8;

  // WIDTH=27 instance
  logic              rst27_n;
  logic              in_valid27, in_ready27, out_valid27, out_ready27;
  logic [2*W27-1:0]  dividend27;
  logic [W27-1:0]    divisor27, quotient27, remainder27;
  logic              dz27, ov27;

  iterative_divider #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(dz8), .overflow(ov8)
  );

  iterative_divider #(.WIDTH(W27)) u_dut27 (
    .clk(clk), .rst_n(rst27_n),
    .in_valid(in_valid27), .in_ready(in_ready27),
    .dividend(dividend27), .divisor(divisor27),
    .out_valid(out_valid27), .out_ready(out_ready27),
    .quotient(quotient27), .remainder(remainder27),
    .div_by_zero(dz27), .overflow(ov27)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation: expected values come from the caller; hold cycles
  // keep out_ready low while hammering in_valid with junk operands.
  task automatic run8(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic edz, input logic eov, input int elat, input int hold);
    int t;
    int lat;
    @(negedge clk);
    t = 0;
    while (!in_ready8 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check({tag, " ready"}, in_ready8, 1'b1);
    dividend8  = dd;
    divisor8   = dv;
    in_valid8  = 1'b1;
    out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    dividend8 = 16'($urandom);
    divisor8  = 8'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " q"}, quotient8, eq);
    check({tag, " r"}, remainder8, er);
    check({tag, " flags"}, {dz8, ov8}, {edz, eov});
    check({tag, " busy"}, in_ready8, 1'b0);
    for (int k = 0; k < hold; k++) begin
      in_valid8 = 1'b1;
      dividend8 = 16'($urandom);
      divisor8  = 8'($urandom);
      @(negedge clk);
      check({tag, " hold"}, {out_valid8, in_ready8, dz8, ov8, quotient8, remainder8},
            {1'b1, 1'b0, edz, eov, eq, er});
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, " handoff"}, {out_valid8, in_ready8}, 2'b01);
  endtask

  // Plain-arithmetic model of a WIDTH=8 result.
  task automatic ref8(input logic [15:0] dd, input logic [7:0] dv,
                      output logic [7:0] q, output logic [7:0] r,
                      output logic dz, output logic ov, output int lat);
    int unsigned a, b;
    a = dd;
    b = dv;
    dz = 0; ov = 0; lat = 0;
    if (b == 0) begin
      dz = 1; q = 8'hFF; r = dd[7:0];
    end else if (a / b > 255) begin
      ov = 1; q = 8'hFF; r = 8'h00;
    end else begin
      q = 8'(a / b); r = 8'(a % b); lat = W8;
    end
  endtask

  initial begin
    logic [15:0] dd;
    logic [7:0]  dv, eq, er;
    logic        edz, eov;
    int          elat;

    rst8_n = 1'b0; rst27_n = 1'b0;
    in_valid8 = 0; out_ready8 = 0; dividend8 = '0; divisor8 = '0;
    in_valid27 = 0; out_ready27 = 0; dividend27 = '0; divisor27 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state8", {in_ready8, out_valid8, dz8, ov8, quotient8, remainder8},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    check("reset state27", {in_ready27, out_valid27, dz27, ov27}, 4'b1000);
    @(negedge clk);
    rst8_n = 1'b1; rst27_n = 1'b1;

    // Error results are decided on the accept edge itself.
    run8("basic",   16'h1234, 8'h56, 8'h36, 8'h10, 0, 0, W8, 0);
    run8("maxq",    16'hFE01, 8'hFF, 8'hFF, 8'h00, 0, 0, W8, 0);
    run8("zero",    16'h0000, 8'h01, 8'h00, 8'h00, 0, 0, W8, 0);
    run8("divzero", 16'h00FF, 8'h00, 8'hFF, 8'hFF, 1, 0, 0,  0);
    run8("ovf",     16'h5600, 8'h56, 8'hFF, 8'h00, 0, 1, 0,  0);
    run8("stall",   16'h1234, 8'h56, 8'h36, 8'h10, 0, 0, W8, 5);

    for (int i = 0; i < 24; i++) begin
      dd = 16'($urandom);
      dv = (i % 3 == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom);
      if (i % 4 == 1) dd[15:8] = 8'($urandom_range(0, 3));
      ref8(dd, dv, eq, er, edz, eov, elat);
      run8("rand8", dd, dv, eq, er, edz, eov, elat, i % 3);
    end

    // Reset three edges into a calculation.
    @(negedge clk);
    dividend8 = 16'h1234; divisor8 = 8'h56; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (2) @(negedge clk);
    rst8_n = 1'b0;
    #1;
    check("mid-calc reset", {in_ready8, out_valid8, dz8, ov8, quotient8, remainder8},
          {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
    @(negedge clk);
    rst8_n = 1'b1;
    for (int k = 0; k < W8 + 2; k++) begin
      @(negedge clk);
      check("post-reset idle", {in_ready8, out_valid8}, 2'b10);
    end
    run8("after reset", 16'h0064, 8'h07, 8'h0E, 8'h02, 0, 0, W8, 0);

    run27();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Random WIDTH=27 traffic: dividend = a*b + r, so the result must be (a, r).
  // Handshakes are judged from what was driven and sampled before each edge.
  task automatic run27();
    longint unsigned exp_q[$];
    longint unsigned exp_r[$];
    longint unsigned a, b, r, cur_a, cur_r;
    int   sent, got, cyc;
    bit   pend;
    logic p_iv, p_ir, p_ov, p_or, p_dz, p_ovf;
    logic [W27-1:0] p_q, p_r;
    sent = 0; got = 0; cyc = 0; pend = 0;
    p_iv = 0; p_ir = 0; p_ov = 0; p_or = 0; p_dz = 0; p_ovf = 0;
    p_q = '0; p_r = '0; cur_a = 0; cur_r = 0;
    while (got < N27 && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (p_iv && p_ir) begin
        exp_q.push_back(cur_a);
        exp_r.push_back(cur_r);
        sent++;
        pend = 0;
      end
      if (p_ov && p_or) begin
        if (exp_q.size() == 0) begin
          check("r27 unexpected result", 64'(exp_q.size()), 64'd1);
        end else begin
          check("r27 q", 64'(p_q), exp_q.pop_front());
          check("r27 r", 64'(p_r), exp_r.pop_front());
          check("r27 flags", {p_dz, p_ovf}, 2'b00);
        end
        got++;
      end
      if (!pend && sent < N27 && $urandom_range(3) != 0) begin
        b = longint'($urandom_range(1, (1 << W27) - 1));
        if ($urandom_range(7) == 0) b = (1 << W27) - 1;
        a = longint'($urandom) & ((64'd1 << W27) - 1);
        r = longint'($urandom_range(0, 32'(b - 1)));
        cur_a = a;
        cur_r = r;
        dividend27 = 54'(a * b + r);
        divisor27  = 27'(b);
        pend = 1;
      end else if (!pend) begin
        dividend27 = 54'({$urandom, $urandom});
        divisor27  = 27'($urandom);
      end
      in_valid27  = pend;
      out_ready27 = ($urandom_range(3) != 0);
      p_iv = in_valid27;  p_ir = in_ready27;
      p_ov = out_valid27; p_or = out_ready27;
      p_q  = quotient27;  p_r  = remainder27;
      p_dz = dz27;        p_ovf = ov27;
    end
    in_valid27 = 0;
    out_ready27 = 0;
    check("r27 results received", 64'(got), 64'(N27));
    check("r27 queue drained", 64'(exp_q.size()), 64'd0);
  endtask

endmodule
`default_nettype wire
